// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a TX FIFO, a serializer drains it onto tx.
// Latency: a push into an empty FIFO is popped on the next edge; tx falls right after that edge.
// Backpressure: none on the bus; a push into a full FIFO with no pop that cycle is dropped and sets overflow.
// Ports: clk/rst_n, CPU bus (a, we, wd, write_byte_enable), combinational rd/hit, serial tx.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [3:0]  write_byte_enable,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    logic [15:0]   baud_div_q;
    state_t        state_q, state_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic wr_en, sel_txdata, sel_status, sel_baud;
    logic fifo_empty, fifo_full, busy;
    logic push_req, push_ok, pop, ovf_set, ovf_clr, bit_end;

    assign hit        = (a[31:4] == BASE_ADDR[31:4]);
    assign wr_en      = we & hit;
    assign sel_txdata = (a[3:2] == 2'd0);
    assign sel_status = (a[3:2] == 2'd1);
    assign sel_baud   = (a[3:2] == 2'd2);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign busy       = (state_q != S_IDLE);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_req = wr_en & sel_txdata & write_byte_enable[0];
    assign push_ok  = push_req & (~fifo_full | pop);
    assign ovf_set  = push_req & ~push_ok;
    assign ovf_clr  = wr_en & sel_status & write_byte_enable[0] & wd[3];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (a[3:2])
                2'd1: begin
                    rd[0]    = fifo_full;
                    rd[1]    = fifo_empty;
                    rd[2]    = busy;
                    rd[3]    = ovf_q;
                    rd[15:8] = 8'(count_q);
                end
                2'd2:    rd[15:0] = baud_div_q;
                default: rd = '0;
            endcase
        end
    end

    // Live compare against BAUD_DIV: shrinking it below the running count ends the bit next cycle.
    assign bit_end = (baud_cnt_q >= baud_div_q);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_q[rd_ptr_q];
                    baud_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx is registered from the next state so the line never glitches on decode.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            baud_div_q <= BAUD_DIV_RESET;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            count_q    <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
            if (wr_en && sel_baud) begin
                if (write_byte_enable[0]) baud_div_q[7:0]  <= wd[7:0];
                if (write_byte_enable[1]) baud_div_q[15:8] <= wd[15:8];
            end
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= wd[7:0];
    end

    assign tx = tx_q;

    logic unused_bits;
    assign unused_bits = ^{a[1:0], wd[31:16], write_byte_enable[3:2]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_BAUD = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [3:0]  write_byte_enable;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;
    logic        tx;

    int   checks = 0;
    int   errors = 0;
    int   cur_div = 9;
    logic mon_en = 1'b0;
    logic [7:0] sb [$];

    mmio_uart_tx dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .a                 (a),
        .write_byte_enable (write_byte_enable),
        .we                (we),
        .wd                (wd),
        .rd                (rd),
        .hit               (hit),
        .tx                (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end 1ns after a rising edge.
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        a = addr; wd = data; write_byte_enable = be; we = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        we = 1'b0; a = '0; wd = '0; write_byte_enable = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        a = addr; we = 1'b0;
        #2 data = rd;
        @(posedge clk); #1;
    endtask

    task automatic set_div(input int div);
        bus_wr(A_BAUD, 32'(div), 4'b0011);
        bus_idle();
        cur_div = div;
    endtask

    // Sample every cycle of one frame and compare to the 8N1 bit pattern of b.
    task automatic tx_expect_frame(input logic [7:0] b, input int div, input string tag);
        logic exp_bit;
        for (int j = 0; j < 10; j++) begin
            exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
            for (int c = 0; c <= div; c++) begin
                @(negedge clk);
                chk(tag, tx, exp_bit);
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        chk("drain", sb.size(), 0);
        repeat (cur_div + 3) @(posedge clk);
        #1;
    endtask

    // Receiver: mid-bit sampling, compares each received byte to the scoreboard head.
    task automatic rx_frame();
        int p;
        logic [7:0] b;
        p = cur_div + 1;
        for (int i = 0; i < p / 2; i++) begin @(negedge clk); if (!mon_en) return; end
        chk("rx_start", tx, 1'b0);
        for (int bi = 0; bi < 8; bi++) begin
            for (int i = 0; i < p; i++) begin @(negedge clk); if (!mon_en) return; end
            b[bi] = tx;
        end
        for (int i = 0; i < p; i++) begin @(negedge clk); if (!mon_en) return; end
        chk("rx_stop", tx, 1'b1);
        chk("rx_expected_frame", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("rx_byte", b, sb.pop_front());
    endtask

    initial begin : monitor
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                prev = 1'b1;
            end else begin
                if (prev && !tx) rx_frame();
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin : main
        logic [31:0] r;
        int lows;
        rst_n = 1'b0;
        bus_idle();

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        chk("t1_tx_in_reset", tx, 1'b1);
        bus_rd(A_STAT, r);
        chk("t1_status_in_reset", r, 32'h0000_0002);
        rst_n = 1'b1;
        bus_rd(A_BAUD, r);
        chk("t1_baud", r, 32'd9);
        a = A_STAT; #1;
        chk("t1_hit", hit, 1'b1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // 2: single byte, 4 cycles per bit, tx falls one cycle after the write edge
        set_div(3);
        sb.push_back(8'h55);
        bus_wr(A_TX, 32'h55, 4'b0001);
        bus_idle();
        @(negedge clk);
        chk("t2_pre_idle", tx, 1'b1);
        tx_expect_frame(8'h55, 3, "t2_bit");
        @(negedge clk);
        chk("t2_post_idle", tx, 1'b1);
        wait_drain(200);

        // 3: six back-to-back pushes, slow baud
        set_div(100);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back(8'(8'h10 + i));
            bus_wr(A_TX, 32'(8'h10 + i), 4'b0001);
        end
        bus_idle();
        bus_rd(A_STAT, r);
        chk("t3_status_full_ovf", r, 32'h0000_040D);
        bus_wr(A_STAT, 32'h8, 4'b0001);
        bus_idle();
        bus_rd(A_STAT, r);
        chk("t3_status_ovf_clr", r, 32'h0000_0405);
        wait_drain(7000);
        bus_rd(A_STAT, r);
        chk("t3_status_idle", r, 32'h0000_0002);

        // 4: pushes that must not land
        bus_wr(A_TX, 32'hA3, 4'b0010);
        bus_idle();
        bus_rd(A_STAT, r);
        chk("t4_lane_status", r, 32'h0000_0002);
        a = BASE + 32'h10; wd = 32'hA3; write_byte_enable = 4'b0001; we = 1'b1;
        #1;
        chk("t4_hit_off", hit, 1'b0);
        chk("t4_rd_off", rd, 32'h0);
        @(posedge clk); #1;
        bus_idle();
        bus_rd(A_STAT, r);
        chk("t4_addr_status", r, 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (!tx) lows++; end
        chk("t4_no_frame", lows, 0);
        @(posedge clk); #1;

        // 6: two queued bytes at 1 cycle/bit, one idle cycle between frames
        set_div(0);
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        bus_wr(A_TX, 32'h00, 4'b0001);
        fork
            begin
                @(negedge clk);
                chk("t6_pre_idle", tx, 1'b1);
                tx_expect_frame(8'h00, 0, "t6_f0_bit");
                @(negedge clk);
                chk("t6_gap", tx, 1'b1);
                tx_expect_frame(8'hFF, 0, "t6_f1_bit");
                @(negedge clk);
                chk("t6_post_idle", tx, 1'b1);
            end
            begin
                bus_wr(A_TX, 32'hFF, 4'b0001);
                bus_idle();
            end
        join
        wait_drain(100);

        // 5: asynchronous reset mid-DATA
        set_div(20);
        sb.push_back(8'h3C);
        bus_wr(A_TX, 32'h3C, 4'b0001);
        bus_idle();
        repeat (31) @(posedge clk);
        #3;
        chk("t5_pre_low", tx, 1'b0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_async_high", tx, 1'b1);
        bus_rd(A_STAT, r);
        chk("t5_status_reset", r, 32'h0000_0002);
        sb.delete();
        rst_n = 1'b1;
        cur_div = 9;
        bus_rd(A_BAUD, r);
        chk("t5_baud_reset", r, 32'd9);
        mon_en = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (!tx) lows++; end
        chk("t5_no_residual", lows, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
